// File: rtl/haz_pkg.sv
// ---------------------------------------------------------------------------
// haz_pkg
// Shared constants for the hazard/forwarding controller.
//   FWD_*  : 3-bit forward-select codes driven on each execute operand mux
//   FWD_W  : width of one forward-select field
//   CNT_W  : width of the optional performance counters
// ---------------------------------------------------------------------------
package haz_pkg;

    localparam int FWD_W = 3;
    localparam int CNT_W = 32;

    localparam logic [FWD_W-1:0] FWD_RF    = 3'd0;  // register file value
    localparam logic [FWD_W-1:0] FWD_RESW  = 3'd1;  // ResultW  (W port 0)
    localparam logic [FWD_W-1:0] FWD_ALUM  = 3'd2;  // ALUOutM  (M port 0)
    localparam logic [FWD_W-1:0] FWD_ALU2M = 3'd3;  // ALUOut2M (M port 1)
    localparam logic [FWD_W-1:0] FWD_RES2W = 3'd4;  // Result2W (W port 1)

endpackage

// File: rtl/haz_fwd_sel.sv
// ---------------------------------------------------------------------------
// haz_fwd_sel
// Forward-select priority encoder for one execute-stage operand. Compares
// the operand tag against the destination tags held in the M and W slots and
// returns the nearest producer.
//
// Ports:
//   src      in  REG_AW         operand register index (E slot)
//   src_v    in  1              operand is actually read
//   m_dst    in  NUM_WP*REG_AW  M-slot destination indices
//   m_dst_v  in  NUM_WP         M-slot per-port write enables
//   w_dst    in  NUM_WP*REG_AW  W-slot destination indices
//   w_dst_v  in  NUM_WP         W-slot per-port write enables
//   sel      out 3              FWD_* code for this operand
// ---------------------------------------------------------------------------
module haz_fwd_sel
    import haz_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int NUM_WP = 2,
    parameter int PC_REG = 15
) (
    input  logic [REG_AW-1:0]        src,
    input  logic                     src_v,
    input  logic [NUM_WP*REG_AW-1:0] m_dst,
    input  logic [NUM_WP-1:0]        m_dst_v,
    input  logic [NUM_WP*REG_AW-1:0] w_dst,
    input  logic [NUM_WP-1:0]        w_dst_v,
    output logic [FWD_W-1:0]         sel
);

    localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

    // The PC is never forwarded: its value comes from the fetch path.
    logic src_ok;
    assign src_ok = src_v && (src != PC_IDX);

    // Only write ports 0 and 1 have result paths back to execute.
    logic [1:0] hit_m;
    logic [1:0] hit_w;

    for (genvar p = 0; p < 2; p++) begin : g_port
        if (p < NUM_WP) begin : g_hit
            assign hit_m[p] = src_ok && m_dst_v[p] && (m_dst[p*REG_AW +: REG_AW] == src);
            assign hit_w[p] = src_ok && w_dst_v[p] && (w_dst[p*REG_AW +: REG_AW] == src);
        end else begin : g_none
            assign hit_m[p] = 1'b0;
            assign hit_w[p] = 1'b0;
        end
    end

    // Youngest producer wins; within one instruction port 0 beats port 1.
    always_comb begin
        sel = FWD_RF;
        if (hit_m[0]) begin
            sel = FWD_ALUM;
        end else if (hit_m[1]) begin
            sel = FWD_ALU2M;
        end else if (hit_w[0]) begin
            sel = FWD_RESW;
        end else if (hit_w[1]) begin
            sel = FWD_RES2W;
        end
    end

endmodule

// File: rtl/hazard_unit_n.sv
// ---------------------------------------------------------------------------
// hazard_unit_n
// Forwarding / hazard controller for the 5-stage core. Tracks the register
// tags of the instructions in E (p0), M (p1) and W (p2) and produces operand
// forward selects, the load-use stall and the branch flush controls.
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   defined   -> stall_cnt / flush_cnt count stall and branch-flush cycles
//   undefined -> both counter outputs are tied to 0, no counter flops
//
// Ports:
//   clk             in  1               clock
//   reset           in  1               synchronous active-high reset
//   d_src           in  NUM_SRC*REG_AW  decode source indices, op i at [i*REG_AW +: REG_AW]
//   d_src_v         in  NUM_SRC         decode per-operand read valid
//   d_dst           in  NUM_WP*REG_AW   decode destination indices
//   d_dst_v         in  NUM_WP          decode per-port write enable
//   d_is_load       in  1               decode instruction loads into port 0
//   branch_taken_e  in  1               branch in execute resolved taken
//   fwd_sel         out NUM_SRC*3       per-operand FWD_* select
//   stall_f         out 1               hold PC
//   stall_d         out 1               hold F/D register
//   flush_d         out 1               clear F/D register
//   flush_e         out 1               bubble into D/E register
//   stall_cnt       out 32              load-use stall cycles
//   flush_cnt       out 32              branch flush cycles
// ---------------------------------------------------------------------------
module hazard_unit_n
    import haz_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int NUM_WP  = 2,
    parameter int REG_AW  = 4,
    parameter int PC_REG  = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC*REG_AW-1:0]  d_src,
    input  logic [NUM_SRC-1:0]         d_src_v,
    input  logic [NUM_WP*REG_AW-1:0]   d_dst,
    input  logic [NUM_WP-1:0]          d_dst_v,
    input  logic                       d_is_load,
    input  logic                       branch_taken_e,
    output logic [NUM_SRC*FWD_W-1:0]   fwd_sel,
    output logic                       stall_f,
    output logic                       stall_d,
    output logic                       flush_d,
    output logic                       flush_e,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

    // Tag slots: p0 = E, p1 = M, p2 = W. The M-slot load flag is not kept:
    // a load reaching M with a dependent in E is prevented by the stall.
    logic [NUM_SRC*REG_AW-1:0] src_p0;
    logic [NUM_SRC-1:0]        src_vld_p0;
    logic [NUM_WP*REG_AW-1:0]  dst_p0;
    logic [NUM_WP-1:0]         dst_vld_p0;
    logic                      load_vld_p0;
    logic [NUM_WP*REG_AW-1:0]  dst_p1;
    logic [NUM_WP-1:0]         dst_vld_p1;
    logic [NUM_WP*REG_AW-1:0]  dst_p2;
    logic [NUM_WP-1:0]         dst_vld_p2;

    logic ld_hit;
    logic ldstall;

    // Decode -> E, E -> M, M -> W: valids (reset and flush apply here)
    always_ff @(posedge clk) begin
        if (reset) begin
            src_vld_p0  <= '0;
            dst_vld_p0  <= '0;
            load_vld_p0 <= 1'b0;
            dst_vld_p1  <= '0;
            dst_vld_p2  <= '0;
        end else begin
            if (flush_e) begin
                src_vld_p0  <= '0;
                dst_vld_p0  <= '0;
                load_vld_p0 <= 1'b0;
            end else begin
                src_vld_p0  <= d_src_v;
                dst_vld_p0  <= d_dst_v;
                load_vld_p0 <= d_is_load;
            end
            dst_vld_p1 <= dst_vld_p0;
            dst_vld_p2 <= dst_vld_p1;
        end
    end

    // Decode -> E, E -> M, M -> W: tags (meaningless while their valid is 0)
    always_ff @(posedge clk) begin
        src_p0 <= d_src;
        dst_p0 <= d_dst;
        dst_p1 <= dst_p0;
        dst_p2 <= dst_p1;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        haz_fwd_sel #(
            .REG_AW (REG_AW),
            .NUM_WP (NUM_WP),
            .PC_REG (PC_REG)
        ) u_fwd_sel (
            .src     (src_p0[i*REG_AW +: REG_AW]),
            .src_v   (src_vld_p0[i]),
            .m_dst   (dst_p1),
            .m_dst_v (dst_vld_p1),
            .w_dst   (dst_p2),
            .w_dst_v (dst_vld_p2),
            .sel     (fwd_sel[i*FWD_W +: FWD_W])
        );
    end

    // Only the primary (load data) port of a load in E can stall decode;
    // the secondary port carries the base writeback, available from M.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (d_src_v[i]
                && (d_src[i*REG_AW +: REG_AW] != PC_IDX)
                && (d_src[i*REG_AW +: REG_AW] == dst_p0[REG_AW-1:0])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign ldstall = load_vld_p0 && dst_vld_p0[0] && ld_hit;

    // A taken branch discards the decode instruction, so it never stalls.
    assign stall_f = ldstall && !branch_taken_e;
    assign stall_d = ldstall && !branch_taken_e;
    assign flush_d = branch_taken_e;
    assign flush_e = ldstall || branch_taken_e;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch_taken_e) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_n.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_n
// Directed instruction sequences for hazard_unit_n. Each cycle the stimulus
// drives one decode instruction and queues the outputs expected in that
// cycle; a negedge monitor pops and compares.
// Counter expectations follow HAZ_PERF_CNT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_hazard_unit_n;
    import haz_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d_src;
    logic [3:0]  d_src_v;
    logic [7:0]  d_dst;
    logic [1:0]  d_dst_v;
    logic        d_is_load;
    logic        branch_taken_e;
    logic [11:0] fwd_sel;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always #5 clk = ~clk;

    hazard_unit_n #(
        .NUM_SRC (4),
        .NUM_WP  (2),
        .REG_AW  (4),
        .PC_REG  (15)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .d_src          (d_src),
        .d_src_v        (d_src_v),
        .d_dst          (d_dst),
        .d_dst_v        (d_dst_v),
        .d_is_load      (d_is_load),
        .branch_taken_e (branch_taken_e),
        .fwd_sel        (fwd_sel),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

`ifdef HAZ_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] fwd;
        logic        stall;
        logic        fl_d;
        logic        fl_e;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    scnt_m      = 0;
    int    fcnt_m      = 0;

    exp_t  mon_e;
    string mon_n;

    function automatic logic [15:0] s4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [11:0] f4(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [7:0] p2(input int a, input int b);
        return {4'(b), 4'(a)};
    endfunction

    // Drive one decode instruction and queue the outputs expected this cycle.
    task automatic cyc(input string nm, input int rst,
                       input logic [15:0] src, input logic [3:0] sv,
                       input logic [7:0] dst, input logic [1:0] dv,
                       input int ld, input int br,
                       input logic [11:0] f, input int st, input int fd, input int fe);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = (rst != 0);
        d_src          = src;
        d_src_v        = sv;
        d_dst          = dst;
        d_dst_v        = dv;
        d_is_load      = (ld != 0);
        branch_taken_e = (br != 0);
        e.fwd   = f;
        e.stall = (st != 0);
        e.fl_d  = (fd != 0);
        e.fl_e  = (fe != 0);
        e.scnt  = CNT_EN ? 32'(scnt_m) : 32'd0;
        e.fcnt  = CNT_EN ? 32'(fcnt_m) : 32'd0;
        sb.push_back(e);
        sb_name.push_back(nm);
        if (rst != 0) begin
            scnt_m = 0;
            fcnt_m = 0;
        end else begin
            if (st != 0) scnt_m++;
            if (br != 0) fcnt_m++;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_n = sb_name.pop_front();
            vectors++;
            if ({fwd_sel, stall_f, stall_d, flush_d, flush_e, stall_cnt, flush_cnt} !==
                {mon_e.fwd, mon_e.stall, mon_e.stall, mon_e.fl_d, mon_e.fl_e, mon_e.scnt, mon_e.fcnt}) begin
                miscompares++;
                $display("FAIL %s: got fwd=%h sf=%b sd=%b fd=%b fe=%b sc=%0d fc=%0d, want fwd=%h sf=sd=%b fd=%b fe=%b sc=%0d fc=%0d",
                         mon_n, fwd_sel, stall_f, stall_d, flush_d, flush_e, stall_cnt, flush_cnt,
                         mon_e.fwd, mon_e.stall, mon_e.fl_d, mon_e.fl_e, mon_e.scnt, mon_e.fcnt);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        d_src          = '0;
        d_src_v        = '0;
        d_dst          = '0;
        d_dst_v        = '0;
        d_is_load      = 1'b0;
        branch_taken_e = 1'b0;
        repeat (2) @(posedge clk);

        //   name            rst src            srcv     dst        dstv  ld br fwd expected      st fd fe
        // 1: back-to-back ALU dependency
        cyc("reset_state",    0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("add_r1",         0, s4(2,3,0,0),  4'b0011, p2(1,0),   2'b01, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("add_r2_r1",      0, s4(1,3,0,0),  4'b0011, p2(2,0),   2'b01, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("fwd_alum",       0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(2,0,0,0), 0, 0, 0);
        // 2: producer two ahead, then secondary-port producer
        cyc("wr_r4",          0, s4(0,0,0,0),  4'b0000, p2(4,0),   2'b01, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("gap",            0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("use_r4",         0, s4(4,0,0,0),  4'b0001, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("fwd_resw",       0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(1,0,0,0), 0, 0, 0);
        cyc("ldr_wb_r4",      0, s4(8,0,0,0),  4'b0001, p2(7,4),   2'b11, 1, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("port1_nostall",  0, s4(4,0,0,0),  4'b0001, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("fwd_alu2m",      0, s4(4,0,0,0),  4'b0001, p2(0,0),   2'b00, 0, 0, f4(3,0,0,0), 0, 0, 0);
        cyc("fwd_res2w",      0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(4,0,0,0), 0, 0, 0);
        // 3: load-use stall
        cyc("ldr_r5",         0, s4(9,0,0,0),  4'b0001, p2(5,0),   2'b01, 1, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("ldstall",        0, s4(5,5,0,0),  4'b0011, p2(6,0),   2'b01, 0, 0, f4(0,0,0,0), 1, 0, 1);
        cyc("stall_bubble",   0, s4(5,5,0,0),  4'b0011, p2(6,0),   2'b01, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("after_stall",    0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(1,1,0,0), 0, 0, 0);
        // 4: PC register is never matched
        cyc("wr_r15",         0, s4(0,0,0,0),  4'b0000, p2(15,0),  2'b01, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("use_r15",        0, s4(15,0,0,0), 4'b0001, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("pc_nofwd",       0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("ldr_r15",        0, s4(0,0,0,0),  4'b0000, p2(15,0),  2'b01, 1, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("pc_nostall",     0, s4(15,0,0,0), 4'b0001, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("pc_nofwd2",      0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        // both ports write r3: port 0 wins in M and in W
        cyc("dual_r3",        0, s4(0,0,0,0),  4'b0000, p2(3,3),   2'b11, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("use_r3_a",       0, s4(3,0,0,0),  4'b0001, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("use_r3_b",       0, s4(0,3,0,0),  4'b0010, p2(0,0),   2'b00, 0, 0, f4(2,0,0,0), 0, 0, 0);
        cyc("dual_w_port0",   0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,1,0,0), 0, 0, 0);
        // M beats W for the same register
        cyc("wr_r10_a",       0, s4(0,0,0,0),  4'b0000, p2(10,0),  2'b01, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("wr_r10_b",       0, s4(0,0,0,0),  4'b0000, p2(10,0),  2'b01, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("use_r10_c",      0, s4(0,0,10,0), 4'b0100, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("m_over_w",       0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,2,0), 0, 0, 0);
        // 5: ldstall and taken branch together, then branch alone
        cyc("ldr_r5_b",       0, s4(0,0,0,0),  4'b0000, p2(5,0),   2'b01, 1, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("stall_vs_br",    0, s4(0,0,0,5),  4'b1000, p2(0,0),   2'b00, 0, 1, f4(0,0,0,0), 0, 1, 1);
        cyc("br_bubble",      0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("br_only",        0, s4(5,0,0,0),  4'b0001, p2(0,0),   2'b00, 0, 1, f4(0,0,0,0), 0, 1, 1);
        cyc("br_bubble2",     0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        // 6: reset while a load sits in E
        cyc("ldr_r5_c",       0, s4(0,0,0,0),  4'b0000, p2(5,0),   2'b01, 1, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("reset_in_stall", 1, s4(5,0,0,0),  4'b0001, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 1, 0, 1);
        cyc("post_reset",     0, s4(5,0,0,0),  4'b0001, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);
        cyc("post_reset2",    0, s4(0,0,0,0),  4'b0000, p2(0,0),   2'b00, 0, 0, f4(0,0,0,0), 0, 0, 0);

        // Bounded drain of the scoreboard.
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
